// File: rtl/uc_reg_loader.sv
// -----------------------------------------------------------------------------
// uc_reg_loader
//
// Purpose
//   Receives configuration frames from a microcontroller over a slow,
//   CLK-asynchronous serial link (CS_N / SCK / MOSI) and commits them
//   atomically into one of two register banks that feed a downstream
//   generator:
//     - DYNREG  (SIZESRDYN bits)  : selector bit 0
//     - STATREG (SIZESRSTAT bits) : selector bit 1
//   Frame on the wire, MSB first, one bit per SCK rising edge:
//     selector, payload[W-1:0] (, even-parity bit)
//   A frame is only committed if it carries exactly the expected number of
//   bits (and correct parity when enabled). Anything else is discarded with a
//   FRAME_ERR pulse. A commit is held off while HOLD is high.
//
// Configuration macro
//   UC_LOADER_PARITY_CHECK_EN : when defined, every frame ends with an even
//   parity bit covering selector + payload; a wrong parity discards the
//   frame. When undefined, frames are 1 + payload bits long, no parity.
//
// Parameters
//   SIZESRDYN   : dynamic register width (default 16)
//   SIZESRSTAT  : static register width (default 88)
//   SYNC_STAGES : synchronizer depth for the uC inputs (>= 2)
//
// Ports
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   UC_CS_N    in   uC frame select, active low, asynchronous
//   UC_SCK     in   uC serial clock, asynchronous
//   UC_MOSI    in   uC serial data
//   HOLD       in   downstream busy; blocks committing
//   DYNREG     out  committed dynamic word
//   STATREG    out  committed static word
//   DYN_VALID  out  set after the first dynamic commit
//   STAT_VALID out  set after the first static commit
//   LOAD_DONE  out  one-cycle pulse per commit
//   FRAME_ERR  out  one-cycle pulse per discarded frame
//   BUSY       out  high whenever the FSM is not IDLE
//   FSM_STATE  out  debug view of the FSM state register
//                   (0 IDLE, 1 SEL, 2 SHIFT, 3 CHECK, 4 PENDING)
//
// Commit contract
//   HOLD works as an inverted "ready" from the consumer: a frame that passed
//   CHECK is held (state PENDING, payload frozen in the shift register) until
//   the first cycle in which HOLD is low; in that cycle the target register,
//   its VALID flag and LOAD_DONE are all written on the same clock edge, so
//   the consumer never observes a partially updated word.
// -----------------------------------------------------------------------------
module uc_reg_loader #(
  parameter int SIZESRDYN   = 16,
  parameter int SIZESRSTAT  = 88,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  UC_CS_N,
  input  logic                  UC_SCK,
  input  logic                  UC_MOSI,
  input  logic                  HOLD,
  output logic [SIZESRDYN-1:0]  DYNREG,
  output logic [SIZESRSTAT-1:0] STATREG,
  output logic                  DYN_VALID,
  output logic                  STAT_VALID,
  output logic                  LOAD_DONE,
  output logic                  FRAME_ERR,
  output logic                  BUSY,
  output logic [2:0]            FSM_STATE
);

`ifdef UC_LOADER_PARITY_CHECK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  localparam int MAXW    = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
  // Shift register holds payload plus the optional parity bit (LSB).
  localparam int SHW     = MAXW + PAR;
  localparam int MAX_LEN = 1 + MAXW + PAR;
  // Counter must be able to exceed the longest legal frame so that an
  // overlong frame never aliases onto a legal length.
  localparam int CNT_W   = $clog2(MAX_LEN + 2);

  localparam logic [CNT_W-1:0] DYN_LEN  = CNT_W'(1 + SIZESRDYN + PAR);
  localparam logic [CNT_W-1:0] STAT_LEN = CNT_W'(1 + SIZESRSTAT + PAR);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL     = 3'd1,
    S_SHIFT   = 3'd2,
    S_CHECK   = 3'd3,
    S_PENDING = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_prev_q;
  logic                   sck_prev_q;

  logic cs_s;
  logic sck_s;
  logic mosi_s;
  logic cs_fall;
  logic cs_rise;
  logic sck_rise;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], UC_CS_N};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], UC_SCK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], UC_MOSI};
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  // MOSI goes through the same depth as SCK, so on a detected SCK rise the
  // synchronized MOSI is the bit the uC set up before that rise.
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // The edge history resets to 0, so a falling CS_N edge can only be seen
  // after CS_N has been observed high following reset release. A frame that
  // was in flight across reset is therefore ignored until it ends.
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;

  // ---------------------------------------------------------------------------
  // Frame capture registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic [SHW-1:0]   shreg_q, shreg_d;

  logic [SIZESRDYN-1:0]  dynreg_q, dynreg_d;
  logic [SIZESRSTAT-1:0] statreg_q, statreg_d;
  logic                  dyn_valid_q, dyn_valid_d;
  logic                  stat_valid_q, stat_valid_d;
  logic                  load_done_q, load_done_d;
  logic                  frame_err_q, frame_err_d;

  logic len_ok;
  logic parity_ok;
  logic frame_ok;

  // cnt_q counts every bit of the frame, selector and parity included.
  assign len_ok = (cnt_q == (sel_q ? STAT_LEN : DYN_LEN));

`ifdef UC_LOADER_PARITY_CHECK_EN
  // par_q is the XOR of every received bit; even parity leaves it at 0.
  assign parity_ok = ~par_q;
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = len_ok & parity_ok;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cs_fall) state_d = S_SEL;
      end
      S_SEL: begin
        // A CS_N rise wins over a coincident SCK rise: the frame is over.
        if (cs_rise)       state_d = S_CHECK;
        else if (sck_rise) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cs_rise) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (frame_ok && HOLD) state_d = S_PENDING;
        else                  state_d = S_IDLE;
      end
      S_PENDING: begin
        // CS_N and SCK activity is deliberately not looked at here.
        if (!HOLD) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  logic commit;
  logic discard;
  logic busy;

  always_comb begin
    commit  = 1'b0;
    discard = 1'b0;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_CHECK: begin
        commit  = frame_ok & ~HOLD;
        discard = ~frame_ok;
      end
      S_PENDING: begin
        commit  = ~HOLD;
      end
      default: begin
        commit  = 1'b0;
        discard = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    shreg_d      = shreg_q;
    dynreg_d     = dynreg_q;
    statreg_d    = statreg_q;
    dyn_valid_d  = dyn_valid_q;
    stat_valid_d = stat_valid_q;
    load_done_d  = commit;
    frame_err_d  = discard;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          sel_d   = 1'b0;
          cnt_d   = '0;
          par_d   = 1'b0;
          shreg_d = '0;
        end
      end
      S_SEL: begin
        if (sck_rise && !cs_rise) begin
          sel_d = mosi_s;
          cnt_d = CNT_W'(1);
          par_d = mosi_s;
        end
      end
      S_SHIFT: begin
        if (sck_rise && !cs_rise) begin
          shreg_d = {shreg_q[SHW-2:0], mosi_s};
          par_d   = par_q ^ mosi_s;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        sel_d = sel_q;
      end
    endcase

    // The payload sits right above the optional parity bit.
    if (commit) begin
      if (sel_q) begin
        statreg_d    = shreg_q[PAR +: SIZESRSTAT];
        stat_valid_d = 1'b1;
      end else begin
        dynreg_d     = shreg_q[PAR +: SIZESRDYN];
        dyn_valid_d  = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q        <= 1'b0;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      shreg_q      <= '0;
      dynreg_q     <= '0;
      statreg_q    <= '0;
      dyn_valid_q  <= 1'b0;
      stat_valid_q <= 1'b0;
      load_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      shreg_q      <= shreg_d;
      dynreg_q     <= dynreg_d;
      statreg_q    <= statreg_d;
      dyn_valid_q  <= dyn_valid_d;
      stat_valid_q <= stat_valid_d;
      load_done_q  <= load_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign DYNREG     = dynreg_q;
  assign STATREG    = statreg_q;
  assign DYN_VALID  = dyn_valid_q;
  assign STAT_VALID = stat_valid_q;
  assign LOAD_DONE  = load_done_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = busy;
  assign FSM_STATE  = state_q;

endmodule

// File: tb/tb_uc_reg_loader.sv
// -----------------------------------------------------------------------------
// tb_uc_reg_loader
//
// Drives serial frames into uc_reg_loader and compares the committed outputs
// against a frame-level reference model: a frame is accepted iff it carries
// exactly the payload width of its bank (and, with parity enabled, an even
// parity bit), and an accepted frame replaces that bank's value.
// -----------------------------------------------------------------------------
module tb_uc_reg_loader;

  localparam int DW   = 16;
  localparam int SW   = 88;
  localparam int NS   = 2;
  localparam int HALF = 6;   // SCK half period in CLK cycles (>= NS+2)

`ifdef UC_LOADER_PARITY_CHECK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs_n;
  logic          sck;
  logic          mosi;
  logic          hold;
  logic [DW-1:0] dynreg;
  logic [SW-1:0] statreg;
  logic          dyn_valid;
  logic          stat_valid;
  logic          load_done;
  logic          frame_err;
  logic          busy;
  logic [2:0]    fsm_state;

  always #5 clk = ~clk;

  uc_reg_loader #(
    .SIZESRDYN  (DW),
    .SIZESRSTAT (SW),
    .SYNC_STAGES(NS)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .UC_CS_N   (cs_n),
    .UC_SCK    (sck),
    .UC_MOSI   (mosi),
    .HOLD      (hold),
    .DYNREG    (dynreg),
    .STATREG   (statreg),
    .DYN_VALID (dyn_valid),
    .STAT_VALID(stat_valid),
    .LOAD_DONE (load_done),
    .FRAME_ERR (frame_err),
    .BUSY      (busy),
    .FSM_STATE (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + scoreboard
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_dyn;
  logic [SW-1:0] m_stat;
  logic          m_dv;
  logic          m_sv;
  // Each entry is {bank select, committed value}, in commit order.
  logic [SW:0]   exp_q[$];
  logic [SW:0]   mon_e;

  function automatic bit even_par(input bit sel, input logic [127:0] data,
                                  input int nbits);
    bit p = sel;
    for (int i = 0; i < nbits; i++) p ^= data[i];
    return p;
  endfunction

  function automatic bit model_frame(input bit sel, input logic [127:0] data,
                                     input int nbits, input bit par_bit);
    int w = sel ? SW : DW;
    bit ok = (nbits == w);
    logic [SW:0] e;
    if (PAR == 1 && par_bit != even_par(sel, data, nbits)) ok = 1'b0;
    if (ok) begin
      e = '0;
      if (sel) begin
        m_stat = data[SW-1:0];
        m_sv   = 1'b1;
        e      = {1'b1, data[SW-1:0]};
      end else begin
        m_dyn  = data[DW-1:0];
        m_dv   = 1'b1;
        e[DW-1:0] = data[DW-1:0];
      end
      exp_q.push_back(e);
    end
    return ok;
  endfunction

  function automatic void model_reset();
    m_dyn  = '0;
    m_stat = '0;
    m_dv   = 1'b0;
    m_sv   = 1'b0;
    exp_q.delete();
  endfunction

  // Every LOAD_DONE pulse must match the oldest outstanding expected commit.
  always @(negedge clk) begin
    if (load_done) begin
      check_eq("load_done_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (mon_e[SW]) check_eq("commit_stat", statreg, mon_e[SW-1:0]);
        else           check_eq("commit_dyn", dynreg, mon_e[DW-1:0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    mosi = b;
    clks(HALF);
    sck = 1'b1;
    clks(HALF);
    sck = 1'b0;
  endtask

  task automatic drive_frame(input bit sel, input logic [127:0] data,
                             input int nbits, input bit par_bit,
                             input bit empty);
    cs_n = 1'b0;
    clks(HALF);
    if (!empty) begin
      send_bit(sel);
      for (int i = nbits - 1; i >= 0; i--) send_bit(data[i]);
      if (PAR == 1) send_bit(par_bit);
    end
    clks(HALF);
    cs_n = 1'b1;
  endtask

  // Counts pulses for `window` cycles; lat is the number of CLK rising edges
  // from the CS_N pin rise to the first visible LOAD_DONE (-1 if none).
  task automatic observe(input int window, output int ld, output int fe,
                         output int lat);
    ld  = 0;
    fe  = 0;
    lat = -1;
    for (int i = 1; i <= window; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (load_done) begin
        ld++;
        if (lat < 0) lat = i;
      end
      if (frame_err) fe++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_dynreg"}, dynreg, m_dyn);
    check_eq({tag, "_statreg"}, statreg, m_stat);
    check_eq({tag, "_dyn_valid"}, dyn_valid, m_dv);
    check_eq({tag, "_stat_valid"}, stat_valid, m_sv);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input bit sel,
                           input logic [127:0] data, input int nbits,
                           input bit bad_par);
    bit par_bit;
    bit accept;
    int ld, fe, lat;
    par_bit = even_par(sel, data, nbits) ^ bad_par;
    accept  = model_frame(sel, data, nbits, par_bit);
    drive_frame(sel, data, nbits, par_bit, 1'b0);
    observe(20, ld, fe, lat);
    check_eq({tag, "_load_done_cnt"}, ld, accept);
    check_eq({tag, "_frame_err_cnt"}, fe, !accept);
    // NS synchronizer edges, one edge into CHECK, one commit edge.
    if (accept) check_eq({tag, "_latency"}, lat, NS + 2);
    check_outputs(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int ld, fe, lat;
    logic [DW-1:0] prev_dyn;
    bit par_bit;
    bit accept;
    bit r_sel;
    int r_w, r_n, r_k;
    logic [127:0] r_data;

    rst_n = 1'b1;
    cs_n  = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    hold  = 1'b0;
    model_reset();
    #3 rst_n = 1'b0;
    clks(5);

    // Reset state
    check_eq("rst_dynreg", dynreg, '0);
    check_eq("rst_statreg", statreg, '0);
    check_eq("rst_dyn_valid", dyn_valid, 1'b0);
    check_eq("rst_stat_valid", stat_valid, 1'b0);
    check_eq("rst_load_done", load_done, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    clks(5);

    // Directed frames
    run_frame("dyn_1234", 1'b0, 128'h1234, 16, 1'b0);
    run_frame("stat_88", 1'b1, 128'hABCDEF123456789ABCDEF1, 88, 1'b0);
    run_frame("trunc15", 1'b0, 128'h1234, 15, 1'b0);
    run_frame("long17", 1'b0, 128'h1ABCD, 17, 1'b0);

    // CS_N pulse with no SCK activity
    drive_frame(1'b0, '0, 0, 1'b0, 1'b1);
    observe(20, ld, fe, lat);
    check_eq("empty_load_done_cnt", ld, 0);
    check_eq("empty_frame_err_cnt", fe, 1);
    check_outputs("empty");

`ifdef UC_LOADER_PARITY_CHECK_EN
    run_frame("par_bad", 1'b0, 128'h0001, 16, 1'b1);
    run_frame("par_good", 1'b0, 128'h0001, 16, 1'b0);
`endif

    // HOLD keeps an accepted frame pending; uC activity meanwhile is ignored.
    hold     = 1'b1;
    prev_dyn = m_dyn;
    par_bit  = even_par(1'b0, 128'hBEEF, 16);
    accept   = model_frame(1'b0, 128'hBEEF, 16, par_bit);
    drive_frame(1'b0, 128'hBEEF, 16, par_bit, 1'b0);
    observe(50, ld, fe, lat);
    check_eq("hold_load_done_cnt", ld, 0);
    check_eq("hold_frame_err_cnt", fe, 0);
    check_eq("hold_busy", busy, 1'b1);
    check_eq("hold_dynreg", dynreg, prev_dyn);
    cs_n = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    check_eq("hold_cs_busy", busy, 1'b1);
    check_eq("hold_cs_dynreg", dynreg, prev_dyn);
    hold = 1'b0;
    observe(20, ld, fe, lat);
    check_eq("release_load_done_cnt", ld, accept);
    check_eq("release_frame_err_cnt", fe, 0);
    check_outputs("release");
    cs_n = 1'b1;
    observe(20, ld, fe, lat);
    check_eq("stray_load_done_cnt", ld, 0);
    check_eq("stray_frame_err_cnt", fe, 0);

    // Reset in the middle of a frame, after 8 payload bits
    cs_n = 1'b0;
    clks(HALF);
    send_bit(1'b0);
    for (int i = 15; i >= 8; i--) send_bit(1'b0);
    rst_n = 1'b0;
    model_reset();
    clks(3);
    check_eq("midrst_dynreg", dynreg, '0);
    check_eq("midrst_statreg", statreg, '0);
    check_eq("midrst_dyn_valid", dyn_valid, 1'b0);
    check_eq("midrst_stat_valid", stat_valid, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(1'b1);
    clks(HALF);
    cs_n = 1'b1;
    observe(20, ld, fe, lat);
    check_eq("postrst_load_done_cnt", ld, 0);
    check_eq("postrst_frame_err_cnt", fe, 0);
    check_outputs("postrst");
    run_frame("after_rst", 1'b0, 128'h00FF, 16, 1'b0);

    // Randomized frames: mostly legal, some one bit short or long,
    // some with a wrong parity bit when parity is enabled.
    for (int n = 0; n < 8; n++) begin
      r_sel  = 1'($urandom_range(0, 1));
      r_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      r_w    = r_sel ? SW : DW;
      r_k    = $urandom_range(0, 3);
      r_n    = (r_k == 2) ? r_w - 1 : (r_k == 3) ? r_w + 1 : r_w;
      run_frame($sformatf("rnd%0d", n), r_sel, r_data, r_n,
                (PAR == 1) && ($urandom_range(0, 3) == 0));
    end

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors",
             n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uc_reg_loader.md
UC_REG_LOADER -- requirements
Module: uc_reg_loader

Interface
REQ-001 The block SHALL have parameter SIZESRDYN, default 16, giving the dynamic register width.
REQ-002 The block SHALL have parameter SIZESRSTAT, default 88, giving the static register width.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for uC inputs (minimum 2).
REQ-004 The block SHALL have port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST_N, input, 1 bit: reset; one clock, reset asynchronous and active-low.
REQ-006 The block SHALL have port UC_CS_N, input, 1 bit: uC frame select, active low, asynchronous to CLK.
REQ-007 The block SHALL have port UC_SCK, input, 1 bit: uC serial clock, asynchronous to CLK.
REQ-008 The block SHALL have port UC_MOSI, input, 1 bit: uC serial data.
REQ-009 The block SHALL have port HOLD, input, 1 bit: downstream generator/FSM busy, so committing is blocked.
REQ-010 The block SHALL have port DYNREG, output, SIZESRDYN bits: committed dynamic word, which feeds the generator DYNREG.
REQ-011 The block SHALL have port STATREG, output, SIZESRSTAT bits: committed static word, which feeds the generator STATREG.
REQ-012 The block SHALL have port DYN_VALID and STAT_VALID, outputs, 1 bit each: set after the first commit of the respective word.
REQ-013 The block SHALL have port LOAD_DONE, output, 1 bit: one-cycle pulse on each commit.
REQ-014 The block SHALL have port FRAME_ERR, output, 1 bit: one-cycle pulse on each discarded frame.
REQ-015 The block SHALL have port BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-016 UC_CS_N, UC_SCK and UC_MOSI SHALL each pass through a SYNC_STAGES flip-flop synchronizer, and edges SHALL be detected on the synchronized copies only.
REQ-017 The uC SHALL hold UC_SCK high and low for at least SYNC_STAGES+2 CLK periods each, and the block is not required to handle faster SCK.
REQ-018 MOSI SHALL be sampled on each synchronized SCK rising edge, MSB first.
REQ-019 Frame format SHALL be: selector bit (0 = dynamic, 1 = static), then the payload (SIZESRDYN or SIZESRSTAT bits), then a parity bit if PARITY_CHECK_EN is defined.
REQ-020 State machine SHALL have the states IDLE, SEL, SHIFT, CHECK and PENDING.
REQ-021 In IDLE, a synchronized CS_N falling edge SHALL move the FSM to SEL.
REQ-022 In SEL, the first SCK rise SHALL latch the selector and move the FSM to SHIFT.
REQ-023 In SHIFT, bits SHALL shift into an internal shift register and a bit counter, saturating at its maximum, SHALL increment.
REQ-024 A synchronized CS_N rising edge SHALL move the FSM from SEL or SHIFT to CHECK.
REQ-025 In CHECK, a frame whose count equals the expected length, with parity correct if enabled, SHALL be accepted; any other frame SHALL pulse FRAME_ERR, be discarded and return the FSM to IDLE.
REQ-026 An accepted frame with HOLD low SHALL commit in the cycle after CHECK: the target output is loaded, its VALID flag set and LOAD_DONE pulsed, and the other output is unchanged.
REQ-027 An accepted frame with HOLD high SHALL move the FSM to PENDING, where the block waits, and SHALL commit in the first cycle with HOLD low.
REQ-028 Outputs SHALL change only on commit and SHALL never show partial data.
REQ-029 A CS_N falling edge during PENDING SHALL be ignored, and any SCK edges before return to IDLE SHALL be ignored.
REQ-030 A CS_N rise with no SCK edges SHALL produce a FRAME_ERR pulse.
REQ-031 Overlong frames SHALL produce a FRAME_ERR pulse.
REQ-032 Latency from the synchronized CS_N rise to LOAD_DONE SHALL be 2 CLK cycles with HOLD low.

Reset
REQ-033 RST_N low SHALL asynchronously force the FSM to IDLE, DYNREG and STATREG to all-zero, DYN_VALID, STAT_VALID, LOAD_DONE, FRAME_ERR and BUSY to 0, and the synchronizers and counters to 0.
REQ-034 Reset asserted mid-frame SHALL discard the frame, and the block SHALL ignore an active frame until CS_N is seen high after reset release.

Configuration
REQ-035 The macro UC_LOADER_PARITY_CHECK_EN SHALL control parity checking: when defined, the frame carries a trailing even-parity bit over the selector and payload, and a mismatch gives FRAME_ERR; when undefined, there is no parity bit and the expected length is 1+payload.

Verification
REQ-036 The bench SHALL send a dynamic frame 0 + 16'h1234 with HOLD low, and SHALL see DYNREG=16'h1234, DYN_VALID=1, one LOAD_DONE pulse, and STATREG still 0.
REQ-037 The bench SHALL send a static frame 1 + 88'hABCDEF123456789ABCDEF1, and SHALL see STATREG equal to that value and STAT_VALID=1.
REQ-038 The bench SHALL send a 0 + 15-bit truncated frame, and SHALL see one FRAME_ERR pulse with DYNREG unchanged.
REQ-039 The bench SHALL send a dynamic frame 0 + 16'hBEEF with HOLD high for 50 cycles, and SHALL see BUSY=1 and DYNREG unchanged until HOLD falls, then LOAD_DONE.
REQ-040 The bench SHALL assert RST_N low after 8 payload bits, then send a full frame 0 + 16'h00FF, and SHALL see outputs 0 after reset and then DYNREG=16'h00FF.
REQ-041 With parity enabled, the bench SHALL send 0 + 16'h0001 with parity bit 0, and SHALL see FRAME_ERR; with parity bit 1 it SHALL see a commit.
